weight_fetch_ctrl: RTL and testbench
====================================

// Module: weight_fetch_ctrl
// PURPOSE
//   Sequences reads from one neuron's weight BRAM (layer/neuron weight memory, 1-cycle
//   registered read) and turns them into a valid/ready weight stream for the neuron MAC.
//   On start, issues numWeight consecutive reads from address 0, absorbs the BRAM read
//   latency in a 3-entry buffer, honours MAC backpressure, flags the last weight and
//   pulses done. Sits between the neuron control FSM and the weight memory instance.
// PARAMETERS
//   numWeight     784  weights per neuron (read count per pass), 1..2**addressWidth
//   addressWidth  10   weight memory address width; raddr is addressWidth+1 bits
//   dataWidth     16   weight word width
// PORTS
//   clk       in   1                 clock, all state on rising edge
//   rst_n     in   1                 asynchronous active-low reset
//   start     in   1                 begin a pass; sampled only in IDLE
//   busy      out  1                 pass in progress
//   done      out  1                 1-cycle pulse: last weight accepted
//   ren       out  1                 weight memory read enable
//   raddr     out  addressWidth+1    weight memory read address
//   wout      in   dataWidth         weight memory read data (valid cycle after ren)
//   w_data    out  dataWidth         weight to MAC
//   w_valid   out  1                 w_data valid
//   w_last    out  1                 w_data is weight numWeight-1
//   w_ready   in   1                 MAC accepts w_data this cycle
// BEHAVIOUR
//   - Reset (rst_n=0, async): state IDLE; busy, done, ren, w_valid, w_last = 0;
//     raddr = 0; w_data = 0; buffer empty; issue/accept counters = 0; inflight = 0.
//   - FSM: IDLE --start--> FETCH --all numWeight reads issued--> DRAIN
//     --last word accepted--> IDLE (done=1 that cycle). start outside IDLE ignored.
//   - busy=1 in FETCH and DRAIN, including the done cycle; 0 in IDLE.
//   - Issue rule (FETCH only): ren=1 iff issued < numWeight and entries+inflight < 3;
//     raddr = issued count; raddr updates only on an issue, holds otherwise.
//     No combinational path from w_ready to ren.
//   - inflight = registered ren; when inflight=1, wout is pushed into the buffer at
//     the end of that cycle. wout is never sampled otherwise.
//   - Buffer: 3-entry FIFO, head drives w_data/w_valid; pop on w_valid&w_ready;
//     push and pop in the same cycle allowed; overflow impossible by issue rule.
//   - w_last = w_valid & (accepted count == numWeight-1). Accept counter increments
//     on each handshake; done pulses on the handshake with w_last=1.
//   - Latency: start high in cycle 0 -> ren=1, raddr=0 in cycle 1 -> w_valid=1 with
//     weight[0] in cycle 3. With w_ready held 1: one weight per cycle, done in cycle
//     numWeight+2.
//   - w_ready=0 stalls: w_data/w_valid/w_last held stable until accepted.
//   - numWeight=1: single read, w_last on first word.
//   - Reset mid-pass: everything returns to reset values immediately; BRAM data
//     returning afterwards is discarded (inflight cleared).
//   - Counters sized $clog2(numWeight+1) bits; no wrap within a pass.
// CONFIGURATION
//   WEIGHT_FETCH_REPEAT_EN defined: adds input repeat_cnt [7:0], sampled with start;
//     the weight set is streamed repeat_cnt+1 times back-to-back (address wraps to 0,
//     no bubble when w_ready=1); w_last asserts on weight numWeight-1 of every pass;
//     done pulses only after the final pass.
//   Undefined: no repeat_cnt port; exactly one pass per start.
// TESTING (bench numWeight=8, memory preloaded mem[i]=i+16'h0100)
//   - Reset then idle: all outputs 0, ren never asserted without start.
//   - start pulse, w_ready=1: ren cycles 1..8 raddr 0..7; w_data 0x0100..0x0107
//     cycles 3..10; w_last and done in cycle 10; busy 1..10.
//   - w_ready toggled 1010..: all 8 words delivered in order, none lost/duplicated,
//     w_data stable while stalled, ren never raises buffer above 3 entries.
//   - start re-asserted during busy: ignored, exactly 8 handshakes, one done.
//   - rst_n low in cycle 5 mid-pass: outputs 0 at once; after release and new start,
//     stream restarts at 0x0100 with no stale word.
//   - WEIGHT_FETCH_REPEAT_EN, repeat_cnt=2: 24 words, w_last at words 8,16,24,
//     single done after word 24.

Source files
------------

// File: rtl/weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// weight_fetch_ctrl
//
// Purpose:
//   Turns a start request into numWeight consecutive reads of one neuron's
//   weight BRAM (1-cycle registered read) and presents the returned words to
//   the neuron MAC as a valid/ready stream. A 3-entry FIFO absorbs the BRAM
//   latency so MAC backpressure never loses a word. The last weight is
//   flagged with w_last and done pulses when the MAC accepts it.
//
// Ports:
//   clk        in   1                rising-edge clock
//   rst_n      in   1                asynchronous active-low reset
//   start      in   1                begin a pass (ignored unless idle)
//   repeat_cnt in   8                extra passes, only with WEIGHT_FETCH_REPEAT_EN
//   busy       out  1                pass in progress
//   done       out  1                one-cycle pulse on final weight handshake
//   ren        out  1                weight memory read enable
//   raddr      out  addressWidth+1   weight memory read address
//   wout       in   dataWidth        weight memory read data (cycle after ren)
//   w_data     out  dataWidth        weight to MAC
//   w_valid    out  1                w_data valid
//   w_last     out  1                w_data is weight numWeight-1
//   w_ready    in   1                MAC accepts w_data this cycle
//
// Configuration:
//   WEIGHT_FETCH_REPEAT_EN  when defined, repeat_cnt is sampled with start and
//                           the weight set streams repeat_cnt+1 times
//                           back-to-back; done pulses only after the last pass.
// ---------------------------------------------------------------------------
module weight_fetch_ctrl #(
    parameter int numWeight    = 784,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
`ifdef WEIGHT_FETCH_REPEAT_EN
    input  logic [7:0]              repeat_cnt,
`endif
    output logic                    busy,
    output logic                    done,
    output logic                    ren,
    output logic [addressWidth:0]   raddr,
    input  logic [dataWidth-1:0]    wout,
    output logic [dataWidth-1:0]    w_data,
    output logic                    w_valid,
    output logic                    w_last,
    input  logic                    w_ready
);

    localparam int            CW       = $clog2(numWeight + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(numWeight - 1);
    localparam logic [CW-1:0] ALL_CNT  = CW'(numWeight);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);
    localparam logic [addressWidth:0] ADDR_ONE = {{addressWidth{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           issued_q, issued_d;
    logic [CW-1:0]           accepted_q, accepted_d;
    logic [addressWidth:0]   raddr_q, raddr_d;
    logic                    inflight_q;
    logic [dataWidth-1:0]    fifo_q [3];
    logic [1:0]              wrPtr_q, wrPtr_d;
    logic [1:0]              rdPtr_q, rdPtr_d;
    logic [1:0]              count_q, count_d;

    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    issueFinalPass;
    logic                    acceptFinalPass;

`ifdef WEIGHT_FETCH_REPEAT_EN
    logic [7:0]              repeat_q, repeat_d;
    logic [7:0]              issuePass_q, issuePass_d;
    logic [7:0]              acceptPass_q, acceptPass_d;

    assign issueFinalPass  = (issuePass_q == repeat_q);
    assign acceptFinalPass = (acceptPass_q == repeat_q);
`else
    assign issueFinalPass  = 1'b1;
    assign acceptFinalPass = 1'b1;
`endif

    // Issue decision uses only registered occupancy (entries plus the read
    // still in flight), so there is no path from w_ready to ren and the FIFO
    // can never be asked to hold more than three words.
    assign issue = (state_q == FETCH) && (issued_q != ALL_CNT)
                   && (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);

    assign push    = inflight_q;
    assign w_valid = (count_q != 2'd0);
    assign pop     = w_valid && w_ready;
    assign w_data  = w_valid ? fifo_q[rdPtr_q] : '0;
    assign w_last  = w_valid && (accepted_q == LAST_IDX);
    assign done    = pop && w_last && acceptFinalPass;
    assign busy    = (state_q != IDLE);
    assign ren     = issue;
    assign raddr   = raddr_q;

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        accepted_d = accepted_q;
        raddr_d    = raddr_q;
`ifdef WEIGHT_FETCH_REPEAT_EN
        repeat_d     = repeat_q;
        issuePass_d  = issuePass_q;
        acceptPass_d = acceptPass_q;
`endif

        if (issue) begin
            if ((issued_q == LAST_IDX) && !issueFinalPass) begin
                // Wrap to address 0 for the next pass without a bubble.
                issued_d = '0;
                raddr_d  = '0;
`ifdef WEIGHT_FETCH_REPEAT_EN
                issuePass_d = issuePass_q + 8'd1;
`endif
            end else begin
                issued_d = issued_q + ONE_CNT;
                raddr_d  = raddr_q + ADDR_ONE;
            end
        end

        if (pop) begin
            if ((accepted_q == LAST_IDX) && !acceptFinalPass) begin
                accepted_d = '0;
`ifdef WEIGHT_FETCH_REPEAT_EN
                acceptPass_d = acceptPass_q + 8'd1;
`endif
            end else begin
                accepted_d = accepted_q + ONE_CNT;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = FETCH;
                    issued_d   = '0;
                    accepted_d = '0;
                    raddr_d    = '0;
`ifdef WEIGHT_FETCH_REPEAT_EN
                    repeat_d     = repeat_cnt;
                    issuePass_d  = '0;
                    acceptPass_d = '0;
`endif
                end
            end
            FETCH: begin
                if (issue && (issued_q == LAST_IDX) && issueFinalPass) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer and occupancy bookkeeping; pointers wrap modulo 3.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (push) begin
            wrPtr_d = (wrPtr_q == 2'd2) ? 2'd0 : wrPtr_q + 2'd1;
        end
        if (pop) begin
            rdPtr_d = (rdPtr_q == 2'd2) ? 2'd0 : rdPtr_q + 2'd1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            accepted_q <= '0;
            raddr_q    <= '0;
            inflight_q <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                fifo_q[i] <= '0;
            end
`ifdef WEIGHT_FETCH_REPEAT_EN
            repeat_q     <= '0;
            issuePass_q  <= '0;
            acceptPass_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            accepted_q <= accepted_d;
            raddr_q    <= raddr_d;
            // Clearing this on reset drops any BRAM word still returning.
            inflight_q <= issue;
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            count_q    <= count_d;
            if (push) begin
                fifo_q[wrPtr_q] <= wout;
            end
`ifdef WEIGHT_FETCH_REPEAT_EN
            repeat_q     <= repeat_d;
            issuePass_q  <= issuePass_d;
            acceptPass_q <= acceptPass_d;
`endif
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_weight_fetch_ctrl
//
// Bench for weight_fetch_ctrl with numWeight=8 and a BRAM model preloaded
// with mem[i] = i + 0x0100. A negedge monitor holds a stream-level model:
// how many reads and handshakes a pass must contain, which address and word
// come next, when busy/done/w_last must be high, and that stalled words hold.
// Stimulus tasks add literal timing and count expectations on top.
// Build with WEIGHT_FETCH_REPEAT_EN to also exercise repeated passes.
// ---------------------------------------------------------------------------
module tb_weight_fetch_ctrl;

    localparam int NW = 8;
    localparam int AW = 10;
    localparam int DW = 16;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          w_ready = 1'b0;
    logic          busy, done, ren, w_valid, w_last;
    logic [AW:0]   raddr;
    logic [DW-1:0] wout = '0;
    logic [DW-1:0] w_data;
`ifdef WEIGHT_FETCH_REPEAT_EN
    logic [7:0]    repeat_cnt = 8'd0;
`endif

    weight_fetch_ctrl #(
        .numWeight   (NW),
        .addressWidth(AW),
        .dataWidth   (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef WEIGHT_FETCH_REPEAT_EN
        .repeat_cnt(repeat_cnt),
`endif
        .busy      (busy),
        .done      (done),
        .ren       (ren),
        .raddr     (raddr),
        .wout      (wout),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_last    (w_last),
        .w_ready   (w_ready)
    );

    always #5 clk = ~clk;

    // Weight BRAM: registered read, data one cycle after ren.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            mem[i] = DW'(i) + 16'h0100;
        end
    end
    always @(posedge clk) begin
        if (ren) wout <= mem[raddr[AW-1:0]];
    end

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    always @(posedge clk) cycle++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Stream model state (updated only by the monitor).
    int            expIssue = 0;
    int            expAccept = 0;
    int            total = NW;
    bit            expBusy = 1'b0;
    bit            prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic          prevLast = 1'b0;

    // Per-pass statistics read by the stimulus tasks.
    int            firstRenCycle, firstValidCycle, doneCycle;
    int            doneCount, hsCount, lastCount;
    logic [DW-1:0] firstData, lastData;

    int            readyMode = 0;

    task automatic clearStats();
        firstRenCycle   = -1;
        firstValidCycle = -1;
        doneCycle       = -1;
        doneCount       = 0;
        hsCount         = 0;
        lastCount       = 0;
        firstData       = '0;
        lastData        = '0;
    endtask

    always @(negedge clk) begin
        bit hs;
        if (!rst_n) begin
            checkOutput("rst_busy",    32'(busy),    32'd0);
            checkOutput("rst_done",    32'(done),    32'd0);
            checkOutput("rst_ren",     32'(ren),     32'd0);
            checkOutput("rst_w_valid", 32'(w_valid), 32'd0);
            checkOutput("rst_w_last",  32'(w_last),  32'd0);
            checkOutput("rst_raddr",   32'(raddr),   32'd0);
            checkOutput("rst_w_data",  32'(w_data),  32'd0);
            expBusy   = 1'b0;
            expIssue  = 0;
            expAccept = 0;
            prevStall = 1'b0;
        end else begin
            hs = w_valid && w_ready;
            checkOutput("busy", 32'(busy), 32'(expBusy));
            if (ren) begin
                if (firstRenCycle < 0) firstRenCycle = cycle;
                checkOutput("ren_in_pass", 32'(expBusy && (expIssue < total)), 32'd1);
                checkOutput("raddr", 32'(raddr), 32'(expIssue % NW));
                // Reads issued but not yet accepted may never exceed 3.
                checkOutput("occupancy", 32'((expIssue - expAccept) <= 2), 32'd1);
                expIssue++;
            end
            if (w_valid) begin
                if (firstValidCycle < 0) begin
                    firstValidCycle = cycle;
                    firstData       = w_data;
                end
                checkOutput("valid_in_pass", 32'(expBusy && (expAccept < total)), 32'd1);
                checkOutput("w_data", 32'(w_data), 32'h0100 + 32'(expAccept % NW));
                checkOutput("w_last", 32'(w_last), 32'((expAccept % NW) == NW - 1));
            end else begin
                checkOutput("w_last_idle", 32'(w_last), 32'd0);
            end
            if (prevStall) begin
                checkOutput("stall_hold", 32'({w_valid, w_last, w_data}),
                            32'({1'b1, prevLast, prevData}));
            end
            checkOutput("done", 32'(done), 32'(hs && (expAccept == total - 1)));
            if (done) begin
                doneCount++;
                doneCycle = cycle;
            end
            if (hs) begin
                hsCount++;
                if (w_last) lastCount++;
                lastData = w_data;
                expAccept++;
            end
            prevStall = w_valid && !w_ready;
            prevData  = w_data;
            prevLast  = w_last;
            if (!expBusy && start) begin
                expBusy   = 1'b1;
                expIssue  = 0;
                expAccept = 0;
`ifdef WEIGHT_FETCH_REPEAT_EN
                total = NW * (int'(repeat_cnt) + 1);
`else
                total = NW;
`endif
            end else if (expBusy && hs && (expAccept == total)) begin
                expBusy = 1'b0;
            end
        end
    end

    // MAC ready pattern: 0 always ready, 1 toggling, 2 random, 3 mostly ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (readyMode)
                0:       w_ready = 1'b1;
                1:       w_ready = ~w_ready;
                2:       w_ready = 1'($urandom_range(0, 1));
                default: w_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    int startCycle;

    // Run one pass: pulse start, optionally re-pulse it randomly while busy,
    // wait (bounded) for done, then check the pass totals.
    task automatic applyStimulus(input int mode, input int rep, input bit noisyStart);
        bit finished;
        readyMode = mode;
`ifdef WEIGHT_FETCH_REPEAT_EN
        repeat_cnt = 8'(rep);
`endif
        clearStats();
        @(posedge clk);
        #1;
        start      = 1'b1;
        startCycle = cycle;
        @(posedge clk);
        #1;
        start    = 1'b0;
        finished = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(posedge clk);
            #1;
            if (doneCount > 0) begin
                finished = 1'b1;
                break;
            end
            if (noisyStart) start = 1'($urandom_range(0, 1));
        end
        start = 1'b0;
        checkOutput("pass_timeout", 32'(finished), 32'd1);
        checkOutput("handshakes", 32'(hsCount), 32'(NW * (rep + 1)));
        checkOutput("done_count", 32'(doneCount), 32'd1);
        checkOutput("last_count", 32'(lastCount), 32'(rep + 1));
        checkOutput("first_word", 32'(firstData), 32'h0100);
        checkOutput("final_word", 32'(lastData), 32'h0107);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        clearStats();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Idle after reset: nothing may be read without start.
        readyMode = 2;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("idle_ren", 32'(ren), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_ren_count", 32'(firstRenCycle), 32'hFFFF_FFFF);

        // Always-ready pass: exact cycle positions.
        applyStimulus(0, 0, 1'b0);
        checkOutput("first_ren_cycle",   32'(firstRenCycle - startCycle),   32'd1);
        checkOutput("first_valid_cycle", 32'(firstValidCycle - startCycle), 32'd3);
        checkOutput("done_cycle",        32'(doneCycle - startCycle),       32'd10);

        // Toggling backpressure.
        applyStimulus(1, 0, 1'b0);

        // Random backpressure with start re-asserted while busy.
        applyStimulus(2, 0, 1'b1);
        applyStimulus(3, 0, 1'b1);

        // Reset in cycle 5 of a pass, then a clean restart.
        readyMode = 0;
        clearStats();
        @(posedge clk);
        #1;
        start      = 1'b1;
        startCycle = cycle;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_hs_before", 32'(hsCount), 32'd2);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_no_stale", 32'(w_valid), 32'd0);
        applyStimulus(2, 0, 1'b0);

        // A few more random passes.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2 + (k % 2), 0, 1'b1);
        end

`ifdef WEIGHT_FETCH_REPEAT_EN
        applyStimulus(0, 2, 1'b0);
        applyStimulus(2, 1, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
